pwm_dac: RTL

PWM_DAC -- requirements
Module: pwm_dac

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_counter.sv | 38 +++
 rtl/pwm_dac.sv | 59 +++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and the offset-binary duty conversion for the PWM DAC.
// One PWM period equals 2^RES clocks, which is also one upstream sample period.
package pwm_pkg;

    localparam int RES_DEFAULT     = 8;
    localparam int MID_DEFAULT     = 1 << (RES_DEFAULT - 1);
    localparam int CLKS_PER_SAMPLE = 1 << RES_DEFAULT;

    function automatic int mid_value(input int res);
        return 1 << (res - 1);
    endfunction

    // Flipping the sign bit maps signed full scale onto 0..2^16-1; the caller keeps the top RES bits.
    function automatic logic [15:0] duty_full(input logic [15:0] sample);
        return {~sample[15], sample[14:0]};
    endfunction

endpackage

// File: rtl/pwm_counter.sv
// RES-bit period counter with run-enable and a wrap strobe in the last cycle of each period.
// A period starts at cnt=0 in the first cycle after en is sampled high.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int RES = RES_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic [RES-1:0] cnt,
    output logic [RES-1:0] cnt_next,
    output logic           wrap
);

    logic run;

    // The edge that first samples en high opens a fresh period at cnt=0 instead of counting.
    always_comb begin
        cnt_next = '0;
        if (en && run) begin
            cnt_next = cnt + RES'(1);
        end
    end

    assign wrap = run && (cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            run <= 1'b0;
        end else begin
            cnt <= cnt_next;
            run <= en;
        end
    end

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC: duty register loaded at period boundaries from din (or mid-scale when muted),
// and a registered PWM bit computed from next-state counter and duty so it never glitches.
module pwm_dac
    import pwm_pkg::*;
#(
    parameter int RES = RES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        mute,
    input  logic [15:0] din,
    output logic        sample_tick,
    output logic        pwm
);

    localparam logic [RES-1:0] MID = RES'(mid_value(RES));

    logic [RES-1:0] cnt;
    logic [RES-1:0] cnt_next;
    logic           wrap;
    logic [RES-1:0] duty_active;
    logic [RES-1:0] duty_next;
    logic [RES-1:0] duty_new;

    pwm_counter #(.RES(RES)) u_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cnt      (cnt),
        .cnt_next (cnt_next),
        .wrap     (wrap)
    );

    // Truncation only: the low din bits are dropped without rounding or dither.
    assign duty_new = RES'(duty_full(din) >> (16 - RES));

    always_comb begin
        duty_next = duty_active;
        if (!en) begin
            duty_next = MID;
        end else if (wrap) begin
            duty_next = mute ? MID : duty_new;
        end
    end

    assign sample_tick = wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_active <= MID;
            pwm         <= 1'b0;
        end else begin
            duty_active <= duty_next;
            pwm         <= en && (cnt_next < duty_next);
        end
    end

endmodule
